// File: rtl/seq_mul32.sv
// Iterative 32x32 shift-and-add multiplier: one 32-bit add per cycle, signed or unsigned,
// with a 64-bit product that holds until the next accepted start.
module seq_mul32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t      state_q, state_d;
  logic [32:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mcand_q, mcand_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [63:0] product_q, product_d;

  logic [31:0] mag_a, mag_b;
  logic [32:0] sum;
  logic [63:0] mag_prod;

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  assign mag_a    = (signed_op && a[31]) ? (~a + 32'd1) : a;
  assign mag_b    = (signed_op && b[31]) ? (~b + 32'd1) : b;
  assign sum      = lo_q[0] ? ({1'b0, hi_q[31:0]} + {1'b0, mcand_q}) : hi_q;
  assign mag_prod = {hi_q[31:0], lo_q};

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = mag_a;
          lo_d    = mag_b;
          hi_d    = 33'd0;
          cnt_d   = 5'd0;
          neg_d   = signed_op & (a[31] ^ b[31]);
          state_d = CALC;
        end
      end
      CALC: begin
        hi_d  = {1'b0, sum[32:1]};
        lo_d  = {sum[0], lo_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = SIGN;
      end
      SIGN: begin
        product_d = neg_q ? (~mag_prod + 64'd1) : mag_prod;
        state_d   = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_q      <= 33'd0;
      lo_q      <= 32'd0;
      mcand_q   <= 32'd0;
      cnt_q     <= 5'd0;
      neg_q     <= 1'b0;
      product_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC) || (state_q == SIGN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mul32.sv
// Directed bench for seq_mul32: latency, busy/done shape, signed/unsigned results,
// start-while-busy, async reset mid-operation and back-to-back starts.
module tb_seq_mul32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int vectors = 0;
  int errors  = 0;

  seq_mul32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Launch one operation, then watch 40 edges; returns the edge index of the first
  // done, the number of busy samples and done samples.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                       output int lat, output int bc, output int dc);
    @(negedge clk);
    a = ia; b = ib; signed_op = is; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; signed_op = $urandom_range(0, 1);
    lat = -1; bc = 0; dc = 0;
    if (busy) bc++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (busy) bc++;
      if (done) begin
        dc++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; a = 32'd0; b = 32'd0;
    #3;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    vectors++; if (product !== 64'h0) begin errors++; $display("FAIL reset_product got %h exp 0", product); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: busy=%b done=%b product=%h", busy, done, product);
  endtask

  task automatic test_unsigned_small;
    int lat, bc, dc;
    do_op(32'd3, 32'd5, 1'b0, lat, bc, dc);
    $display("unsigned 3*5: product=%h lat=%0d busy_cycles=%0d done_cycles=%0d", product, lat, bc, dc);
    vectors++; if (product !== 64'd15) begin errors++; $display("FAIL small_product got %h exp %h", product, 64'd15); end
    vectors++; if (lat !== 33) begin errors++; $display("FAIL small_latency got %0d exp 33", lat); end
    vectors++; if (bc !== 33) begin errors++; $display("FAIL small_busy_cycles got %0d exp 33", bc); end
    vectors++; if (dc !== 1) begin errors++; $display("FAIL small_done_cycles got %0d exp 1", dc); end
  endtask

  task automatic test_unsigned_max;
    int lat, bc, dc;
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bc, dc);
    $display("unsigned max: product=%h lat=%0d", product, lat);
    vectors++; if (product !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL umax_product got %h exp FFFFFFFE00000001", product); end
    vectors++; if (lat !== 33) begin errors++; $display("FAIL umax_latency got %0d exp 33", lat); end
  endtask

  task automatic test_signed;
    int lat, bc, dc;
    do_op(32'hFFFFFFFD, 32'd7, 1'b1, lat, bc, dc);
    $display("signed -3*7: product=%h lat=%0d", product, lat);
    vectors++; if (product !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL sneg_product got %h exp FFFFFFFFFFFFFFEB", product); end
    vectors++; if (lat !== 33) begin errors++; $display("FAIL sneg_latency got %0d exp 33", lat); end
    do_op(32'h80000000, 32'h80000000, 1'b1, lat, bc, dc);
    $display("signed min*min: product=%h", product);
    vectors++; if (product !== 64'h40000000_00000000) begin errors++; $display("FAIL smin_product got %h exp 4000000000000000", product); end
    do_op(32'd0, 32'hFFFFFFFF, 1'b1, lat, bc, dc);
    $display("signed 0*-1: product=%h done_cycles=%0d", product, dc);
    vectors++; if (product !== 64'h0) begin errors++; $display("FAIL szero_product got %h exp 0", product); end
    vectors++; if (dc !== 1) begin errors++; $display("FAIL szero_done_cycles got %0d exp 1", dc); end
  endtask

  task automatic test_start_while_busy;
    int dc = 0;
    logic [63:0] p33 = 64'h0;
    logic busy34 = 1'b1, busy35 = 1'b0;
    @(negedge clk);
    a = 32'd2; b = 32'd9; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk);
      #1;
      if (done && k <= 34) dc++;
      if (k == 4)  begin start = 1'b1; a = 32'd100; end
      if (k == 5)  start = 1'b0;
      if (k == 33) begin p33 = product; start = 1'b1; a = 32'd3; b = 32'd3; end
      if (k == 34) busy34 = busy;
      if (k == 35) begin busy35 = busy; start = 1'b0; end
    end
    $display("start while busy: product@33=%h done_cycles=%0d busy@34=%b busy@35=%b final=%h", p33, dc, busy34, busy35, product);
    vectors++; if (p33 !== 64'd18) begin errors++; $display("FAIL swb_product got %h exp %h", p33, 64'd18); end
    vectors++; if (dc !== 1) begin errors++; $display("FAIL swb_done_cycles got %0d exp 1", dc); end
    vectors++; if (busy34 !== 1'b0) begin errors++; $display("FAIL swb_busy_n34 got %b exp 0", busy34); end
    vectors++; if (busy35 !== 1'b1) begin errors++; $display("FAIL swb_busy_n35 got %b exp 1", busy35); end
    vectors++; if (product !== 64'd9) begin errors++; $display("FAIL swb_second_product got %h exp %h", product, 64'd9); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, dc;
    @(negedge clk);
    a = 32'd5; b = 32'd5; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    $display("reset mid-op: busy=%b done=%b product=%h", busy, done, product);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", done); end
    vectors++; if (product !== 64'h0) begin errors++; $display("FAIL rmid_product got %h exp 0", product); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd6, 32'd7, 1'b0, lat, bc, dc);
    $display("after reset 6*7: product=%h lat=%0d busy_cycles=%0d", product, lat, bc);
    vectors++; if (product !== 64'd42) begin errors++; $display("FAIL rmid_after_product got %h exp %h", product, 64'd42); end
    vectors++; if (lat !== 33) begin errors++; $display("FAIL rmid_after_latency got %0d exp 33", lat); end
    vectors++; if (bc !== 33) begin errors++; $display("FAIL rmid_after_busy_cycles got %0d exp 33", bc); end
  endtask

  task automatic test_back_to_back;
    int first_k = -1, second_k = -1, dc = 0;
    logic [63:0] p_first = 64'h0, p_mid = 64'h0, p_second = 64'h0;
    @(negedge clk);
    a = 32'd4; b = 32'd4; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 32'd5; b = 32'd5;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dc++;
        if (first_k < 0) begin first_k = k; p_first = product; end
        else begin second_k = k; p_second = product; end
      end
      if (k == 50) p_mid = product;
      if (k == 69) start = 1'b0;
    end
    $display("continuous start: first@%0d=%h mid=%h second@%0d=%h done_cycles=%0d", first_k, p_first, p_mid, second_k, p_second, dc);
    vectors++; if (first_k !== 33) begin errors++; $display("FAIL b2b_first_edge got %0d exp 33", first_k); end
    vectors++; if (p_first !== 64'd16) begin errors++; $display("FAIL b2b_first_product got %h exp %h", p_first, 64'd16); end
    vectors++; if (p_mid !== 64'd16) begin errors++; $display("FAIL b2b_hold_product got %h exp %h", p_mid, 64'd16); end
    vectors++; if (second_k !== 68) begin errors++; $display("FAIL b2b_second_edge got %0d exp 68", second_k); end
    vectors++; if (p_second !== 64'd25) begin errors++; $display("FAIL b2b_second_product got %h exp %h", p_second, 64'd25); end
    vectors++; if (dc !== 2) begin errors++; $display("FAIL b2b_done_cycles got %0d exp 2", dc); end
  endtask

  initial begin
    test_reset();
    test_unsigned_small();
    test_unsigned_max();
    test_signed();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
